roll_judge: RTL and testbench

ROLL_JUDGE -- requirements
Module: roll_judge

---
 rtl/roll_judge.sv | 132 +++++++++++++
 tb/tb_roll_judge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/roll_judge.sv
// Craps-style dice roll judge: an LFSR spins two dice, then the sum is scored
// against the come-out / point rules and reported with a one-cycle done pulse.
module roll_judge #(
    parameter int          SPIN_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_req,
    input  logic       clear_i,
    input  logic       force_en,
    input  logic [2:0] force_a,
    input  logic [2:0] force_b,
    output logic [2:0] die_a,
    output logic [2:0] die_b,
    output logic [3:0] point,
    output logic [1:0] result,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SPIN, EVAL, REPORT} state_t;

    localparam logic [7:0]  SPIN_LOAD = 8'(SPIN_CYCLES - 1);
    localparam logic [1:0]  RES_CONT  = 2'b00;
    localparam logic [1:0]  RES_LOST  = 2'b01;
    localparam logic [1:0]  RES_WON   = 2'b10;

    state_t      state, next_state;
    logic [15:0] lfsr;
    logic [7:0]  spin_cnt;
    logic [2:0]  cand_a, cand_b;
    logic [2:0]  eval_a, eval_b;
    logic [3:0]  sum;
    logic [1:0]  next_result;
    logic [3:0]  next_point;

    function automatic logic face_ok(input logic [2:0] v);
        return (v >= 3'd1) && (v <= 3'd6);
    endfunction

    assign cand_a = lfsr[2:0];
    assign cand_b = lfsr[5:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (roll_req) next_state = SPIN;
                SPIN:    if (spin_cnt == 8'd0) next_state = EVAL;
                EVAL:    next_state = REPORT;
                REPORT:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        done = (state == REPORT);
        busy = (state != IDLE);
    end

    // Forced faces override the spun ones only when they are legal die values.
    always_comb begin
        eval_a      = (force_en && face_ok(force_a)) ? force_a : die_a;
        eval_b      = (force_en && face_ok(force_b)) ? force_b : die_b;
        sum         = {1'b0, eval_a} + {1'b0, eval_b};
        next_result = RES_CONT;
        next_point  = point;
        if (point == 4'd0) begin
            if (sum == 4'd7 || sum == 4'd11) begin
                next_result = RES_WON;
                next_point  = 4'd0;
            end else if (sum == 4'd2 || sum == 4'd3 || sum == 4'd12) begin
                next_result = RES_LOST;
                next_point  = 4'd0;
            end else begin
                next_point  = sum;
            end
        end else if (sum == point) begin
            next_result = RES_WON;
            next_point  = 4'd0;
        end else if (sum == 4'd7) begin
            next_result = RES_LOST;
            next_point  = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            spin_cnt <= 8'd0;
            die_a    <= 3'd1;
            die_b    <= 3'd1;
            point    <= 4'd0;
            result   <= RES_CONT;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

            if (state == IDLE && roll_req && !clear_i)
                spin_cnt <= SPIN_LOAD;
            else if (state == SPIN && spin_cnt != 8'd0)
                spin_cnt <= spin_cnt - 8'd1;

            if (state == SPIN) begin
                if (face_ok(cand_a)) die_a <= cand_a;
                if (face_ok(cand_b)) die_b <= cand_b;
            end else if (state == EVAL) begin
                die_a <= eval_a;
                die_b <= eval_b;
            end

            if (clear_i) begin
                point  <= 4'd0;
                result <= RES_CONT;
            end else if (state == EVAL) begin
                point  <= next_point;
                result <= next_result;
            end
        end
    end

endmodule

// File: tb/tb_roll_judge.sv
// Scoreboard bench for roll_judge: stimulus pushes expected outcomes, a
// monitor pops and compares them whenever done pulses.
module tb_roll_judge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       roll_req, clear_i, force_en;
    logic [2:0] force_a, force_b;
    logic [2:0] die_a, die_b;
    logic [3:0] point;
    logic [1:0] result;
    logic       done, busy;

    typedef struct {
        int         cyc;
        logic [1:0] res;
        logic [3:0] pt;
        logic [2:0] a;
        logic [2:0] b;
    } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  exp_a, exp_b;
    logic [3:0]  exp_pt;

    roll_judge #(.SPIN_CYCLES(16), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .roll_req(roll_req), .clear_i(clear_i),
        .force_en(force_en), .force_a(force_a), .force_b(force_b),
        .die_a(die_a), .die_b(die_b), .point(point), .result(result),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [5:0] judge(input logic [3:0] s, input logic [3:0] pt);
        if (pt == 4'd0) begin
            if (s == 4'd7 || s == 4'd11) return {2'b10, 4'd0};
            if (s == 4'd2 || s == 4'd3 || s == 4'd12) return {2'b01, 4'd0};
            return {2'b00, s};
        end
        if (s == pt) return {2'b10, 4'd0};
        if (s == 4'd7) return {2'b01, 4'd0};
        return {2'b00, pt};
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_output("unexpected_done", 1, 0);
            end else begin
                sb_t it;
                it = sb.pop_front();
                check_output("done_cycle", cyc, it.cyc);
                check_output("result", int'(result), int'(it.res));
                check_output("point", int'(point), int'(it.pt));
                check_output("die_a", int'(die_a), int'(it.a));
                check_output("die_b", int'(die_b), int'(it.b));
                check_output("die_a_range", int'(die_a >= 3'd1 && die_a <= 3'd6), 1);
                check_output("die_b_range", int'(die_b >= 3'd1 && die_b <= 3'd6), 1);
            end
        end
    end

    task automatic apply_stimulus(input logic fen, input logic [2:0] fa, input logic [2:0] fb,
                                  input bit use_hand, input logic [1:0] hres, input logic [3:0] hpt,
                                  input bit extra_req, input int clear_at);
        int         t;
        logic [2:0] ca, cb;
        logic [3:0] s;
        logic [5:0] j;
        sb_t        it;
        @(negedge clk);
        roll_req = 1'b1;
        force_en = fen;
        force_a  = fa;
        force_b  = fb;
        t        = cyc;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            roll_req = extra_req && (i == 5 || i == 18);
            clear_i  = (clear_at != 0) && (i == clear_at);
            if (i <= 16 && (clear_at == 0 || i <= clear_at)) begin
                ca = m_lfsr[2:0];
                cb = m_lfsr[5:3];
                if (ca >= 3'd1 && ca <= 3'd6) exp_a = ca;
                if (cb >= 3'd1 && cb <= 3'd6) exp_b = cb;
            end
            check_output("busy", int'(busy), (clear_at == 0) ? int'(i <= 18) : int'(i <= clear_at));
            if (clear_at == 0 && i == 17) begin
                if (fen && fa >= 3'd1 && fa <= 3'd6) exp_a = fa;
                if (fen && fb >= 3'd1 && fb <= 3'd6) exp_b = fb;
                s = {1'b0, exp_a} + {1'b0, exp_b};
                j = judge(s, exp_pt);
                it.cyc = t + 18;
                it.res = use_hand ? hres : j[5:4];
                it.pt  = use_hand ? hpt : j[3:0];
                it.a   = exp_a;
                it.b   = exp_b;
                sb.push_back(it);
                exp_pt = it.pt;
            end
            if (clear_at != 0 && i == clear_at + 1) begin
                check_output("clear_point", int'(point), 0);
                check_output("clear_result", int'(result), 0);
                exp_pt = 4'd0;
            end
        end
        roll_req = 1'b0;
        clear_i  = 1'b0;
        if (clear_at == 0)
            check_output("done_seen", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_die_a"}, int'(die_a), 1);
        check_output({tag, "_die_b"}, int'(die_b), 1);
        check_output({tag, "_point"}, int'(point), 0);
        check_output({tag, "_result"}, int'(result), 0);
        check_output({tag, "_done"}, int'(done), 0);
        check_output({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; roll_req = 1'b0; clear_i = 1'b0;
        force_en = 1'b0; force_a = 3'd0; force_b = 3'd0;
        exp_a = 3'd1; exp_b = 3'd1; exp_pt = 4'd0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Forced rolls with hand-computed outcomes
        apply_stimulus(1, 3'd3, 3'd4, 1, 2'b10, 4'd0, 0, 0);
        apply_stimulus(1, 3'd2, 3'd2, 1, 2'b00, 4'd4, 0, 0);
        apply_stimulus(1, 3'd1, 3'd3, 1, 2'b10, 4'd0, 0, 0);
        apply_stimulus(1, 3'd6, 3'd6, 1, 2'b01, 4'd0, 0, 0);
        apply_stimulus(1, 3'd4, 3'd5, 1, 2'b00, 4'd9, 0, 0);
        apply_stimulus(1, 3'd5, 3'd2, 1, 2'b01, 4'd0, 0, 0);

        // Illegal forced values keep the spun faces
        apply_stimulus(1, 3'd0, 3'd7, 0, 2'b00, 4'd0, 0, 0);
        apply_stimulus(1, 3'd3, 3'd0, 0, 2'b00, 4'd0, 0, 0);

        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        exp_pt = 4'd0;
        check_output("idle_clear_point", int'(point), 0);
        check_output("idle_clear_result", int'(result), 0);

        // Requests during SPIN and REPORT are ignored
        apply_stimulus(1, 3'd6, 3'd5, 1, 2'b10, 4'd0, 1, 0);

        // Abort mid-roll with clear_i at T+5
        apply_stimulus(1, 3'd2, 3'd2, 1, 2'b00, 4'd4, 0, 0);
        apply_stimulus(1, 3'd1, 3'd1, 0, 2'b00, 4'd0, 0, 5);
        apply_stimulus(1, 3'd6, 3'd4, 1, 2'b00, 4'd10, 0, 0);

        @(negedge clk);
        roll_req = 1'b1;
        clear_i  = 1'b1;
        @(negedge clk);
        roll_req = 1'b0;
        clear_i  = 1'b0;
        exp_pt   = 4'd0;
        check_output("same_cycle_busy", int'(busy), 0);
        check_output("same_cycle_point", int'(point), 0);
        repeat (20) @(negedge clk);
        check_output("same_cycle_busy_late", int'(busy), 0);

        for (int r = 0; r < 1000; r++)
            apply_stimulus(0, 3'd0, 3'd0, 0, 2'b00, 4'd0, 0, 0);

        // Reset in the middle of SPIN
        @(negedge clk);
        roll_req = 1'b1;
        force_en = 1'b1;
        force_a  = 3'd2;
        force_b  = 3'd2;
        @(negedge clk);
        roll_req = 1'b0;
        repeat (5) @(negedge clk);
        check_output("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_a = 3'd1; exp_b = 3'd1; exp_pt = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check_output("post_reset_busy", int'(busy), 0);
        apply_stimulus(1, 3'd6, 3'd5, 1, 2'b10, 4'd0, 0, 0);

        repeat (5) @(negedge clk);
        check_output("queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
